// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM_P stream loader.
//   loader_state_e : FSM state encoding (IDLE, LOAD, DONE)
//   StateWidth     : width of the state register
package ram_loader_pkg;

  localparam int unsigned StateWidth = 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StDone = 2'b10
  } loader_state_e;

endpackage

// File: rtl/ram_p_stream_loader.sv
// Upstream fill stage for the RAM_P matrix RAM. Each beat accepted on the stream slave
// port becomes one registered write at sequential addresses starting at 0; `done` pulses
// in the cycle of the final write. A frame is started by `start` while idle.
//
// Optional feature macro: LOADER_TLAST_CHECK_EN
//   defined   : s_axis_tlast is checked; early tlast ends the frame, missing tlast on the
//               final beat flags an error; frame_err is sticky until the next start.
//   undefined : s_axis_tlast is ignored and frame_err stays 0.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           one-cycle frame request, sampled only when idle
//   s_axis_tdata    stream data          s_axis_tvalid  stream data valid
//   s_axis_tready   beat can be accepted s_axis_tlast   final beat marker
//   write_enable    RAM write strobe     write_address  RAM write address
//   RAM_in          RAM write data
//   busy            high while loading   done           one-cycle completion pulse
//   frame_err       sticky framing error
module ram_p_stream_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 4,
  parameter int unsigned WORD_COUNT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RAM_WIDTH-1:0]     s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] write_address,
  output logic [RAM_WIDTH-1:0]     RAM_in,
  output logic                     busy,
  output logic                     done,
  output logic                     frame_err
);

  // Index of the last word; the counter stops here instead of wrapping, so a full
  // 2**RAM_ADDR_BITS frame never overflows it.
  localparam logic [RAM_ADDR_BITS-1:0] LastIdx = RAM_ADDR_BITS'(WORD_COUNT - 1);

  loader_state_e              state_q;
  logic [RAM_ADDR_BITS-1:0]   cnt_q;
  logic                       we_q;
  logic [RAM_ADDR_BITS-1:0]   addr_q;
  logic [RAM_WIDTH-1:0]       data_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       err_q;

  logic beat;
  logic at_last;
  logic early_end;
  logic err_set;

  // Ready depends on the state register alone, never on tvalid.
  assign s_axis_tready = (state_q == StLoad);
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign at_last       = (cnt_q == LastIdx);

`ifdef LOADER_TLAST_CHECK_EN
  assign early_end = s_axis_tlast && !at_last;
  assign err_set   = early_end || (at_last && !s_axis_tlast);
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign early_end    = 1'b0;
  assign err_set      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle; address and data hold between writes.
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (beat) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q;
            data_q <= s_axis_tdata;
            if (err_set) begin
              err_q <= 1'b1;
            end
            if (at_last || early_end) begin
              // Final write and done land in the same cycle.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + RAM_ADDR_BITS'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign RAM_in        = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_err     = err_q;

endmodule
